// File: rtl/imem_access_arbiter.sv
// Arbitrates the single-port instruction memory between the fetch path (reads)
// and the program loader (writes), returning read data one cycle after the grant.
module imem_access_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int INSTR_W        = 9,
    parameter int MAX_LOAD_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_lock,
    input  logic               fetch_req,
    input  logic [31:0]        fetch_addr,
    output logic               fetch_gnt,
    output logic               fetch_rvalid,
    output logic [INSTR_W-1:0] fetch_rdata,
    output logic               fetch_oob,
    input  logic               load_req,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic               load_gnt,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOAD_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOAD_BURST);

    typedef enum logic {
        NORMAL,
        FORCE_FETCH
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               fetch_rvalid_q, fetch_rvalid_d;
    logic               fetch_oob_q, fetch_oob_d;
    logic [INSTR_W-1:0] rdata_hold_q, rdata_hold_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= NORMAL;
            burst_cnt_q    <= '0;
            fetch_rvalid_q <= 1'b0;
            fetch_oob_q    <= 1'b0;
            rdata_hold_q   <= '0;
        end else begin
            state_q        <= state_d;
            burst_cnt_q    <= burst_cnt_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            fetch_oob_q    <= fetch_oob_d;
            rdata_hold_q   <= rdata_hold_d;
        end
    end

    // Download lock overrides everything; FORCE_FETCH flips the priority for one grant.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (load_lock) begin
            load_gnt = load_req;
        end else if (state_q == FORCE_FETCH) begin
            fetch_gnt = fetch_req;
            load_gnt  = load_req & ~fetch_req;
        end else begin
            load_gnt  = load_req;
            fetch_gnt = fetch_req & ~load_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            NORMAL: begin
                if (load_gnt && fetch_req && !load_lock) begin
                    burst_cnt_d = (burst_cnt_q == MAX_CNT) ? MAX_CNT : burst_cnt_q + 1'b1;
                    if (burst_cnt_q == MAX_CNT - 1'b1) begin
                        state_d = FORCE_FETCH;
                    end
                end else begin
                    burst_cnt_d = '0;
                end
            end
            FORCE_FETCH: begin
                if (fetch_gnt || !fetch_req || load_lock) begin
                    state_d     = NORMAL;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = NORMAL;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Memory steering and read return; the hold register keeps the last fetched word.
    always_comb begin
        mem_en         = fetch_gnt | load_gnt;
        mem_we         = load_gnt;
        mem_addr       = load_gnt ? load_addr : fetch_addr[ADDR_W-1:0];
        mem_wdata      = load_gnt ? load_data : '0;
        fetch_rdata    = fetch_rvalid_q ? mem_rdata : rdata_hold_q;
        rdata_hold_d   = fetch_rdata;
        fetch_rvalid_d = fetch_gnt;
        fetch_oob_d    = fetch_gnt & (|fetch_addr[31:ADDR_W]);
        fetch_rvalid   = fetch_rvalid_q;
        fetch_oob      = fetch_oob_q;
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Self-checking bench for imem_access_arbiter: a behavioural grant/memory model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_imem_access_arbiter;

    localparam int ADDR_W   = 12;
    localparam int INSTR_W  = 9;
    localparam int MAXBURST = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               load_lock = 1'b0;
    logic               fetch_req = 1'b0;
    logic [31:0]        fetch_addr = '0;
    logic               fetch_gnt;
    logic               fetch_rvalid;
    logic [INSTR_W-1:0] fetch_rdata;
    logic               fetch_oob;
    logic               load_req = 1'b0;
    logic [ADDR_W-1:0]  load_addr = '0;
    logic [INSTR_W-1:0] load_data = '0;
    logic               load_gnt;
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic [INSTR_W-1:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    logic [INSTR_W-1:0] memResp [DEPTH];
    logic [INSTR_W-1:0] memGold [DEPTH];

    int                 consecLoads = 0;
    logic               expRvalid = 1'b0;
    logic               expOob = 1'b0;
    logic [INSTR_W-1:0] expRdata = '0;
    logic               modelFetchGnt = 1'b0;
    logic               modelLoadGnt = 1'b0;

    imem_access_arbiter #(
        .ADDR_W(ADDR_W),
        .INSTR_W(INSTR_W),
        .MAX_LOAD_BURST(MAXBURST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_lock(load_lock),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid),
        .fetch_rdata(fetch_rdata),
        .fetch_oob(fetch_oob),
        .load_req(load_req),
        .load_addr(load_addr),
        .load_data(load_data),
        .load_gnt(load_gnt),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory array attached to the DUT: write-then-read across cycles, read data next cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) memResp[mem_addr] <= mem_wdata;
            else        mem_rdata <= memResp[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: priority to the loader unless it has already won MAXBURST times in a
    // row against a waiting fetch; the lock blocks fetch outright.
    always @(negedge clk) begin
        logic eF, eL;
        if (!reset) begin
            checkOutput("rst_rvalid", fetch_rvalid, 1'b0);
            checkOutput("rst_oob", fetch_oob, 1'b0);
            checkOutput("rst_rdata", fetch_rdata, '0);
            consecLoads   = 0;
            expRvalid     = 1'b0;
            expOob        = 1'b0;
            expRdata      = '0;
            modelFetchGnt = 1'b0;
            modelLoadGnt  = 1'b0;
        end else begin
            checkOutput("rvalid", fetch_rvalid, expRvalid);
            checkOutput("oob", fetch_oob, expOob);
            checkOutput("rdata", fetch_rdata, expRdata);
            eF = 1'b0;
            eL = 1'b0;
            if (load_lock) begin
                eL = load_req;
            end else if (fetch_req && load_req) begin
                if (consecLoads >= MAXBURST) eF = 1'b1;
                else                         eL = 1'b1;
            end else begin
                eL = load_req;
                eF = fetch_req;
            end
            checkOutput("fetch_gnt", fetch_gnt, eF);
            checkOutput("load_gnt", load_gnt, eL);
            checkOutput("mem_en", mem_en, eF | eL);
            checkOutput("mem_we", mem_we, eL);
            checkOutput("mem_addr", mem_addr, eL ? load_addr : fetch_addr[ADDR_W-1:0]);
            checkOutput("mem_wdata", mem_wdata, eL ? load_data : '0);
            if (load_lock || !fetch_req || eF) consecLoads = 0;
            else if (eL)                       consecLoads = consecLoads + 1;
            expRvalid = eF;
            expOob    = eF && (fetch_addr[31:ADDR_W] != '0);
            if (eF) expRdata = memGold[fetch_addr[ADDR_W-1:0]];
            if (eL) memGold[load_addr] = load_data;
            modelFetchGnt = eF;
            modelLoadGnt  = eL;
        end
    end

    // Drives one cycle of inputs just after the rising edge and returns shortly before the
    // falling edge so directed checks can sample the combinational outputs.
    task automatic applyStimulus(input logic lock, input logic fReq, input logic [31:0] fAddr,
                                 input logic lReq, input logic [ADDR_W-1:0] lAddr,
                                 input logic [INSTR_W-1:0] lData);
        @(posedge clk);
        #1;
        load_lock  = lock;
        fetch_req  = fReq;
        fetch_addr = fAddr;
        load_req   = lReq;
        load_addr  = lAddr;
        load_data  = lData;
        #3;
    endtask

    initial begin
        logic               rLock, rF, rL;
        logic [31:0]        rFA;
        logic [ADDR_W-1:0]  rLA;
        logic [INSTR_W-1:0] rLD;

        for (int i = 0; i < DEPTH; i++) begin
            memResp[i] = INSTR_W'($urandom);
            memGold[i] = memResp[i];
        end
        memResp[5] = 9'h1A3;
        memGold[5] = 9'h1A3;

        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, '0, '0);

        // Fetch only from a preloaded word; the returned value must persist afterwards.
        applyStimulus(1'b0, 1'b1, 32'h5, 1'b0, '0, '0);
        checkOutput("t2_gnt", fetch_gnt, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
        checkOutput("t2_rvalid", fetch_rvalid, 1'b1);
        checkOutput("t2_rdata", fetch_rdata, 9'h1A3);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
        checkOutput("t2_rvalid_drop", fetch_rvalid, 1'b0);
        checkOutput("t2_hold", fetch_rdata, 9'h1A3);

        // Write then read back the same word, first in range and then aliased out of range.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 12'h010, 9'h0FF);
        checkOutput("t5_load_gnt", load_gnt, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 1'b0, '0, '0);
        checkOutput("t5_fetch_gnt", fetch_gnt, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_1010, 1'b0, '0, '0);
        checkOutput("t5_rdata", fetch_rdata, 9'h0FF);
        checkOutput("t5_oob_clear", fetch_oob, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
        checkOutput("t5_alias_rdata", fetch_rdata, 9'h0FF);
        checkOutput("t5_oob", fetch_oob, 1'b1);

        // Both requesters saturated: four loader grants, then one fetch, repeating.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, ADDR_W'(12'h100 + i), INSTR_W'(i * 7));
            checkOutput($sformatf("t3_load_gnt%0d", i), load_gnt, (i % 5) != 4);
            checkOutput($sformatf("t3_fetch_gnt%0d", i), fetch_gnt, (i % 5) == 4);
        end

        // Download lock: fetch is never granted, every write goes through.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, ADDR_W'(12'h180 + i), INSTR_W'(i + 3));
            checkOutput($sformatf("t4_fetch_gnt%0d", i), fetch_gnt, 1'b0);
            checkOutput($sformatf("t4_load_gnt%0d", i), load_gnt, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, '0, '0);
        checkOutput("t4_fetch_after_lock", fetch_gnt, 1'b1);

        // Reset lands while a granted read is still in flight.
        applyStimulus(1'b0, 1'b1, 32'h5, 1'b0, '0, '0);
        checkOutput("t1_gnt", fetch_gnt, 1'b1);
        #3;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
        checkOutput("t1_rvalid", fetch_rvalid, 1'b0);
        checkOutput("t1_rdata", fetch_rdata, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
        checkOutput("t1_no_late_rvalid", fetch_rvalid, 1'b0);
        checkOutput("t1_rdata_after", fetch_rdata, '0);

        // Random traffic; each request stays up with stable payload until granted.
        rLock = 1'b0;
        rF    = 1'b0;
        rL    = 1'b0;
        rFA   = '0;
        rLA   = '0;
        rLD   = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!rF || modelFetchGnt) begin
                rF  = ($urandom_range(0, 3) != 0);
                rFA = {($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'h0,
                       12'($urandom_range(0, 31))};
            end
            if (!rL || modelLoadGnt) begin
                rL  = ($urandom_range(0, 2) != 0);
                rLA = ADDR_W'($urandom_range(0, 31));
                rLD = INSTR_W'($urandom);
            end
            if ($urandom_range(0, 24) == 0) rLock = ~rLock;
            applyStimulus(rLock, rF, rFA, rL, rLA, rLD);
        end

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
